// File: rtl/ppc60x_bus_arbiter_if.sv
// Shared PowerPC 60x arbitration wires: bus requests and handshakes toward the
// arbiter, address/data grants and busy flags back out.
interface ppc60x_bus_arbiter_if #(
  parameter int unsigned N_MASTERS = 2
);
  logic [N_MASTERS-1:0] BR;
  logic                 TS;
  logic [4:0]           TT;
  logic                 TBST;
  logic                 AACK;
  logic                 ARTRY;
  logic                 TA;
  logic [N_MASTERS-1:0] BG;
  logic [N_MASTERS-1:0] DBG;
  logic                 ABUSY;
  logic                 DBUSY;

  modport master (
    output BR, TS, TT, TBST, AACK, ARTRY, TA,
    input  BG, DBG, ABUSY, DBUSY
  );

  modport slave (
    input  BR, TS, TT, TBST, AACK, ARTRY, TA,
    output BG, DBG, ABUSY, DBUSY
  );
endinterface

// File: rtl/ppc60x_bus_arbiter.sv
// PowerPC 60x central arbiter: round-robin address grants, data grants issued
// in address-acknowledge order through a small tenure queue.
module ppc60x_bus_arbiter #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned TS_TIMEOUT = 4
) (
  input logic                 CLK,
  input logic                 RST,
  ppc60x_bus_arbiter_if.slave bus
);
  localparam int unsigned OWN_W  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned TCNT_W = $clog2(TS_TIMEOUT + 1);

  typedef enum logic [1:0] {A_IDLE, A_GRANT, A_TENURE, A_WIN} a_state_e;
  typedef enum logic [1:0] {D_IDLE, D_GRANT, D_TENURE}        d_state_e;

  typedef struct packed {
    logic [OWN_W-1:0] owner;
    logic             burst;
  } q_entry_t;

  a_state_e             a_state_q, a_state_d;
  d_state_e             d_state_q, d_state_d;
  logic [N_MASTERS-1:0] bg_q, bg_d, dbg_q, dbg_d;
  logic                 abusy_q, abusy_d, dbusy_q, dbusy_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d, a_owner_q, a_owner_d;
  logic                 a_burst_q, a_burst_d, a_aonly_q, a_aonly_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [1:0]           beat_q, beat_d;
  q_entry_t             q_mem_q [2];
  q_entry_t             q_mem_d [2];
  logic                 q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CNT_W-1:0]     q_cnt_q, q_cnt_d;

  logic                 push, pop, found;
  logic [OWN_W-1:0]     pick, cand;
  logic [3:0]           req;
  q_entry_t             head;
  logic                 unused_tt;

  assign unused_tt = ^{bus.TT[4], bus.TT[2:0]};

  function automatic logic [N_MASTERS-1:0] grant_n(input logic [OWN_W-1:0] idx);
    logic [3:0] v;
    v      = 4'hF;
    v[idx] = 1'b0;
    return v[N_MASTERS-1:0];
  endfunction

  // Queue pointers toggle for a two-entry queue and stay put for a single entry.
  function automatic logic q_next(input logic p);
    return (PIPE_DEPTH > 1) ? ~p : 1'b0;
  endfunction

  always_comb begin
    a_state_d = a_state_q;
    d_state_d = d_state_q;
    bg_d      = '1;
    dbg_d     = '1;
    rr_ptr_d  = rr_ptr_q;
    a_owner_d = a_owner_q;
    a_burst_d = a_burst_q;
    a_aonly_d = a_aonly_q;
    tcnt_d    = tcnt_q;
    beat_d    = beat_q;
    q_mem_d   = q_mem_q;
    q_wr_d    = q_wr_q;
    q_rd_d    = q_rd_q;
    push      = 1'b0;
    pop       = 1'b0;
    head      = q_mem_q[q_rd_q];
    cand      = '0;

    // Round-robin search starting just after the last granted master.
    req                = '0;
    req[N_MASTERS-1:0] = ~bus.BR;
    found              = 1'b0;
    pick               = rr_ptr_q;
    for (int i = 1; i <= int'(N_MASTERS); i++) begin
      cand = OWN_W'((int'(rr_ptr_q) + i) % int'(N_MASTERS));
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    unique case (a_state_q)
      A_IDLE: begin
        // No tenure is in flight while idle, so only queued tenures count.
        if (found && (q_cnt_q < CNT_W'(PIPE_DEPTH))) begin
          bg_d      = grant_n(pick);
          rr_ptr_d  = pick;
          a_owner_d = pick;
          tcnt_d    = '0;
          a_state_d = A_GRANT;
        end
      end
      A_GRANT: begin
        if (!bus.TS) begin
          a_burst_d = !bus.TBST;
          a_aonly_d = bus.TT[3];
          a_state_d = A_TENURE;
        end else if (tcnt_q == TCNT_W'(TS_TIMEOUT - 1)) begin
          a_state_d = A_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          bg_d   = grant_n(a_owner_q);
        end
      end
      A_TENURE: begin
        if (!bus.AACK) a_state_d = A_WIN;
      end
      A_WIN: begin
        push      = bus.ARTRY && !a_aonly_q;
        a_state_d = A_IDLE;
      end
      default: a_state_d = A_IDLE;
    endcase

    unique case (d_state_q)
      D_IDLE: begin
        if (q_cnt_q != '0) begin
          dbg_d     = grant_n(head.owner);
          d_state_d = D_GRANT;
        end
      end
      D_GRANT: begin
        beat_d    = '0;
        d_state_d = D_TENURE;
      end
      D_TENURE: begin
        if (!bus.TA) begin
          if (beat_q == (head.burst ? 2'd3 : 2'd0)) begin
            pop       = 1'b1;
            d_state_d = D_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: d_state_d = D_IDLE;
    endcase

    if (push) begin
      q_mem_d[q_wr_q].owner = a_owner_q;
      q_mem_d[q_wr_q].burst = a_burst_q;
      q_wr_d                = q_next(q_wr_q);
    end
    if (pop) q_rd_d = q_next(q_rd_q);
    q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);

    abusy_d = (a_state_d != A_IDLE);
    dbusy_d = (d_state_d != D_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_state_q <= A_IDLE;
      d_state_q <= D_IDLE;
      bg_q      <= '1;
      dbg_q     <= '1;
      abusy_q   <= 1'b0;
      dbusy_q   <= 1'b0;
      rr_ptr_q  <= OWN_W'(N_MASTERS - 1);
      a_owner_q <= '0;
      a_burst_q <= 1'b0;
      a_aonly_q <= 1'b0;
      tcnt_q    <= '0;
      beat_q    <= '0;
      q_wr_q    <= 1'b0;
      q_rd_q    <= 1'b0;
      q_cnt_q   <= '0;
      for (int i = 0; i < 2; i++) q_mem_q[i] <= '0;
    end else begin
      a_state_q <= a_state_d;
      d_state_q <= d_state_d;
      bg_q      <= bg_d;
      dbg_q     <= dbg_d;
      abusy_q   <= abusy_d;
      dbusy_q   <= dbusy_d;
      rr_ptr_q  <= rr_ptr_d;
      a_owner_q <= a_owner_d;
      a_burst_q <= a_burst_d;
      a_aonly_q <= a_aonly_d;
      tcnt_q    <= tcnt_d;
      beat_q    <= beat_d;
      q_wr_q    <= q_wr_d;
      q_rd_q    <= q_rd_d;
      q_cnt_q   <= q_cnt_d;
      q_mem_q   <= q_mem_d;
    end
  end

  assign bus.BG    = bg_q;
  assign bus.DBG   = dbg_q;
  assign bus.ABUSY = abusy_q;
  assign bus.DBUSY = dbusy_q;
endmodule
